// File: rtl/pixel_row_serializer_pkg.sv
// Shared pixel sensor configuration: array geometry, readout bus sizing and
// the readout FSM state type.
package pixel_row_serializer_pkg;

  localparam int unsigned PIXEL_ARRAY_HEIGHT = 12;
  localparam int unsigned PIXEL_ARRAY_WIDTH  = 24;
  localparam int unsigned PIXEL_BITS         = 8;
  localparam int unsigned OUTPUT_BUS_WIDTH   = 8;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  // Output beats needed to carry one full row.
  localparam int unsigned READOUT_BEATS = ceil_div(PIXEL_ARRAY_WIDTH, OUTPUT_BUS_WIDTH);

  typedef enum logic {IDLE, SEND} readout_state_t;

endpackage

// File: rtl/pixel_row_serializer.sv
// Row readout serializer: captures a full pixel row and streams it out
// BUS_WIDTH pixels per beat with valid/ready, tagging row/frame boundaries.
module pixel_row_serializer
  import pixel_row_serializer_pkg::*;
#(
  parameter int unsigned HEIGHT     = PIXEL_ARRAY_HEIGHT,
  parameter int unsigned WIDTH      = PIXEL_ARRAY_WIDTH,
  parameter int unsigned PIXEL_BITS = pixel_row_serializer_pkg::PIXEL_BITS,
  parameter int unsigned BUS_WIDTH  = OUTPUT_BUS_WIDTH,
  localparam int unsigned ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            row_valid,
  output logic                            row_ready,
  input  logic [WIDTH*PIXEL_BITS-1:0]     row_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BUS_WIDTH*PIXEL_BITS-1:0] out_data,
  output logic [ROW_W-1:0]                out_row,
  output logic                            out_last_row_beat,
  output logic                            out_last_frame_beat,
  output logic                            frame_done
);

  localparam int unsigned BEATS  = ceil_div(WIDTH, BUS_WIDTH);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);

  readout_state_t                state;
  logic [BEAT_W-1:0]             beat;
  logic [ROW_W-1:0]              row;
  logic [WIDTH*PIXEL_BITS-1:0]   row_buf;
  logic                          last_beat;

  assign last_beat           = (state == SEND) && (beat == LAST_BEAT);
  assign out_valid           = (state == SEND);
  assign out_row             = row;
  assign out_last_row_beat   = last_beat;
  assign out_last_frame_beat = last_beat && (row == LAST_ROW);
  // A new row can slip in on the final-beat handshake so back-to-back rows have no bubble.
  assign row_ready = !reset && ((state == IDLE) || (last_beat && out_ready));

  // Lane multiplexer: lane k carries pixel beat*BUS_WIDTH+k, zero past the row end.
  always_comb begin
    int unsigned pix;
    pix      = 0;
    out_data = '0;
    for (int unsigned k = 0; k < BUS_WIDTH; k++) begin
      pix = 32'(beat) * BUS_WIDTH + k;
      if (pix < WIDTH) begin
        out_data[k*PIXEL_BITS +: PIXEL_BITS] = row_buf[pix*PIXEL_BITS +: PIXEL_BITS];
      end
    end
  end

  // Readout FSM with beat/row counters, row buffer and frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= '0;
      row        <= '0;
      row_buf    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (row_valid) begin
            row_buf <= row_data;
            beat    <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (beat != LAST_BEAT) begin
              beat <= beat + 1'b1;
            end else begin
              row        <= (row == LAST_ROW) ? '0 : row + 1'b1;
              frame_done <= (row == LAST_ROW);
              beat       <= '0;
              if (row_valid) begin
                row_buf <= row_data;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_row_serializer.sv
// Bench for pixel_row_serializer: directed scenarios plus randomized traffic,
// all checked against a queue-of-beats reference model.
module tb_pixel_row_serializer;
  import pixel_row_serializer_pkg::*;

  localparam int unsigned H     = 12;
  localparam int unsigned W     = 24;
  localparam int unsigned PB    = 8;
  localparam int unsigned BW    = 8;
  localparam int unsigned BEATS = (W + BW - 1) / BW;
  localparam int unsigned W2    = 20;
  localparam int unsigned DW    = BW * PB;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            row_valid = 1'b0;
  logic            row_ready;
  logic [W*PB-1:0] row_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [3:0]      out_row;
  logic            out_last_row_beat;
  logic            out_last_frame_beat;
  logic            frame_done;

  logic             rv20 = 1'b0;
  logic             rr20;
  logic [W2*PB-1:0] rd20 = '0;
  logic             ov20;
  logic             ordy20 = 1'b0;
  logic [DW-1:0]    od20;
  logic [3:0]       orow20;
  logic             lrb20;
  logic             lfb20;
  logic             fd20;

  pixel_row_serializer u_dut (
    .clk                 (clk),
    .reset               (reset),
    .row_valid           (row_valid),
    .row_ready           (row_ready),
    .row_data            (row_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_row             (out_row),
    .out_last_row_beat   (out_last_row_beat),
    .out_last_frame_beat (out_last_frame_beat),
    .frame_done          (frame_done)
  );

  pixel_row_serializer #(
    .WIDTH (W2)
  ) u_dut20 (
    .clk                 (clk),
    .reset               (reset),
    .row_valid           (rv20),
    .row_ready           (rr20),
    .row_data            (rd20),
    .out_valid           (ov20),
    .out_ready           (ordy20),
    .out_data            (od20),
    .out_row             (orow20),
    .out_last_row_beat   (lrb20),
    .out_last_frame_beat (lfb20),
    .frame_done          (fd20)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   row;
    bit            last_row;
    bit            last_frame;
  } beat_t;

  beat_t       q[$];
  int unsigned row_m = 0;
  bit          fd_exp = 1'b0;
  bit          rst_seen = 1'b0;
  bit          acc = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          dut_beats = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each accepted row becomes BEATS queued beats; checks run mid-cycle.
  always @(negedge clk) begin : model
    bit    ev;
    bit    er;
    beat_t nb[BEATS];
    ev = (q.size() > 0);
    er = !reset && ((q.size() == 0) || ((q.size() == 1) && out_ready));
    check("out_valid", out_valid, ev);
    check("row_ready", row_ready, er);
    check("frame_done", frame_done, fd_exp);
    check("out_row", out_row, ev ? q[0].row : row_m);
    check("last_row_beat", out_last_row_beat, ev && q[0].last_row);
    check("last_frame_beat", out_last_frame_beat, ev && q[0].last_frame);
    if (ev) check("out_data", out_data, q[0].data);
    if (rst_seen) check("reset_data", out_data, 64'd0);
    if (out_valid && out_ready) dut_beats++;

    rst_seen = reset;
    if (reset) begin
      q.delete();
      row_m  = 0;
      fd_exp = 1'b0;
      acc    = 1'b0;
    end else begin
      fd_exp = ev && out_ready && q[0].last_frame;
      if (ev && out_ready) void'(q.pop_front());
      acc = row_valid && er;
      if (acc) begin
        for (int b = 0; b < BEATS; b++) begin
          nb[b].data       = '0;
          nb[b].row        = row_m;
          nb[b].last_row   = (b == BEATS - 1);
          nb[b].last_frame = (b == BEATS - 1) && (row_m == H - 1);
        end
        for (int i = 0; i < W; i++) begin
          nb[i / BW].data[(i % BW)*PB +: PB] = row_data[i*PB +: PB];
        end
        for (int b = 0; b < BEATS; b++) q.push_back(nb[b]);
        row_m = (row_m + 1) % H;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W*PB-1:0] fill(input int unsigned v);
    logic [W*PB-1:0] r;
    for (int i = 0; i < W; i++) r[i*PB +: PB] = PB'(v);
    return r;
  endfunction

  function automatic logic [W*PB-1:0] rnd_row();
    logic [W*PB-1:0] r;
    for (int i = 0; i < W * PB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic feed_row(input logic [W*PB-1:0] d);
    bit got;
    got       = 1'b0;
    row_data  = d;
    row_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = acc;
    end
    row_valid = 1'b0;
    if (!got) check("accept_timeout", 1'b0, 1'b1);
    repeat (3) cycle();
  endtask

  initial begin : stim
    logic [DW-1:0]   e20;
    logic [W*PB-1:0] ramp;
    int              r;
    int              base;

    repeat (3) cycle();
    reset = 1'b0;

    // Single ramp row on the main DUT; WIDTH=20 instance runs alongside.
    for (int i = 0; i < W; i++) ramp[i*PB +: PB] = PB'(i);
    for (int i = 0; i < W2; i++) rd20[i*PB +: PB] = PB'(i + 1);
    row_data  = ramp;
    row_valid = 1'b1;
    out_ready = 1'b1;
    rv20      = 1'b1;
    ordy20    = 1'b1;
    cycle();
    row_valid = 1'b0;
    rv20      = 1'b0;
    e20 = '0;
    for (int k = 0; k < BW; k++) e20[k*PB +: PB] = PB'(k + 1);
    check("w20_beat0", od20, e20);
    cycle();
    cycle();
    e20 = '0;
    for (int k = 0; k < 4; k++) e20[k*PB +: PB] = PB'(16 + k + 1);
    check("w20_valid", ov20, 1'b1);
    check("w20_beat2", od20, e20);
    check("w20_last", lrb20, 1'b1);
    repeat (3) cycle();

    // Backpressure during beat 1.
    row_data  = rnd_row();
    row_valid = 1'b1;
    cycle();
    row_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    repeat (4) cycle();

    // Full frame back-to-back, pixel value = row index.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    r         = 0;
    row_data  = fill(0);
    row_valid = 1'b1;
    cycle();
    base = dut_beats;
    for (int i = 0; i < 36; i++) begin
      if (acc) begin
        if (r < H - 1) begin
          r++;
          row_data = fill(r);
        end else begin
          row_valid = 1'b0;
        end
      end
      cycle();
    end
    check("frame_beats_36", dut_beats - base, 36);
    row_valid = 1'b0;
    repeat (3) cycle();

    // Reset during beat 1 of row 5.
    for (int i = 0; i < 5; i++) feed_row(rnd_row());
    row_data  = rnd_row();
    row_valid = 1'b1;
    cycle();
    row_valid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    feed_row(rnd_row());

    // Randomized traffic; upstream holds row_valid/row_data until accepted.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      reset     = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!row_valid || acc) begin
        row_valid = ($urandom_range(0, 2) != 0);
        row_data  = rnd_row();
      end
    end

    reset     = 1'b0;
    row_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pixel_row_serializer.md
# pixel_row_serializer

Readout stage directly downstream of the pixel array. Accepts one full row of pixel values in parallel and serializes it onto the output bus, `OUTPUT_BUS_WIDTH` pixels per beat, with valid/ready flow control. It tracks row position within the frame, marks row and frame boundaries for the output consumer, and runs entirely in the main sensor clock domain.

## Interface
- `HEIGHT`, default `PixelSensorConfig::PIXEL_ARRAY_HEIGHT` (12): rows per frame.
- `WIDTH`, default `PixelSensorConfig::PIXEL_ARRAY_WIDTH` (24): pixels per row.
- `PIXEL_BITS`, default `PixelSensorConfig::PIXEL_BITS` (8): bits per pixel.
- `BUS_WIDTH`, default `PixelSensorConfig::OUTPUT_BUS_WIDTH` (8): pixels per output beat.
- Ports (one clock; reset is synchronous and active-high):
  - `clk` in, 1: main clock; all state changes on the rising edge.
  - `reset` in, 1: synchronous, active-high.
  - `row_valid` in, 1: `row_data` holds a complete row.
  - `row_ready` out, 1: block accepts a row this cycle.
  - `row_data` in, `WIDTH*PIXEL_BITS`: pixel *i* occupies bits `[i*PIXEL_BITS +: PIXEL_BITS]`.
  - `out_valid` out, 1: beat present on `out_data`.
  - `out_ready` in, 1: consumer accepts the beat.
  - `out_data` out, `BUS_WIDTH*PIXEL_BITS`: lane *k* carries pixel `beat*BUS_WIDTH + k`.
  - `out_row` out, `$clog2(HEIGHT)`: row index of the current beat.
  - `out_last_row_beat` out, 1: final beat of a row.
  - `out_last_frame_beat` out, 1: final beat of row `HEIGHT-1`.
  - `frame_done` out, 1: one-cycle pulse after the last frame beat is accepted.

## Operation
- `BEATS = ceil(WIDTH/BUS_WIDTH)`: 3 at the defaults.
- State machine `IDLE`, `SEND`:
  - `IDLE`: `row_ready=1`, `out_valid=0`. On `row_valid&&row_ready`: capture `row_data` into the row buffer, set `beat=0`, go to `SEND`.
  - `SEND`: `out_valid=1`. On `out_valid&&out_ready`:
    - If `beat<BEATS-1`: increment `beat`.
    - Otherwise (last beat): advance `row`, wrapping `HEIGHT-1` to 0. If `row_valid` is high in the same cycle, capture the new row and restart at `beat=0` in `SEND`; otherwise return to `IDLE`.
- `row_ready = !reset && (state==IDLE || (state==SEND && beat==BEATS-1 && out_ready))`.
- Partial last beat when `WIDTH` is not a multiple of `BUS_WIDTH`: lanes past `WIDTH-1` output 0.
- Markers:
  - `out_last_row_beat = (state==SEND && beat==BEATS-1)`.
  - `out_last_frame_beat = out_last_row_beat && row==HEIGHT-1`.
- While `out_valid && !out_ready`: `out_data`, `out_row` and both markers hold stable.
- `row_data` is sampled only on accept; it may change freely at other times.

## Timing
- Reset values:
  - outputs: `out_valid=0`, `out_data=0` (buffer cleared), `out_row=0`, both markers 0, `frame_done=0`, `row_ready=0` while `reset` is high.
  - internal: state `IDLE`, `beat=0`.
- Latency: a row accepted at edge *n* presents beat 0 from edge *n* onward, i.e. visible in cycle *n+1*.
- Throughput:
  - With `out_ready` held high and rows presented back-to-back: one beat per cycle, no bubble between rows.
  - A frame at the defaults takes 36 beats in 36 cycles after the first accept.
- `frame_done`: asserted in the cycle after the `HEIGHT-1`, `BEATS-1` beat handshake, for exactly one cycle.
- Reset mid-row: the current row is discarded with no further beats, `row` returns to 0, and the block accepts a new row on the first cycle after `reset` deasserts.
- `row_valid` in `SEND` before the last-beat handshake: ignored (`row_ready=0`); the upstream holds it.

## Structure
- Additions to the shared `PixelSensorConfig` package:
  - `localparam READOUT_BEATS`, derived from `PIXEL_ARRAY_WIDTH` and `OUTPUT_BUS_WIDTH`.
  - `typedef enum logic {IDLE, SEND} readout_state_t`.
- Single module; the beat-to-lane multiplexer is an inline `always_comb`, so no sub-module.
- Row buffer: one `WIDTH*PIXEL_BITS` register. Counters: `beat` is `$clog2(BEATS)` bits, `row` is `$clog2(HEIGHT)` bits.

## Test plan
- Single row, default parameters, pixel *i* = *i*, `out_ready=1`:
  - beats in order: 0..7, 8..15, 16..23.
  - `out_last_row_beat` on beat 2 only; `row_ready` returns high the following cycle.
- Backpressure: drop `out_ready` for 5 cycles mid-beat 1 → `out_data` holds pixels 8..15, `out_row` unchanged, no beat lost or duplicated.
- Full frame, back-to-back rows with pixel value = row index:
  - 36 beats in 36 cycles.
  - `out_row` goes 0..11; `out_last_frame_beat` on beat 35.
  - `frame_done` pulses once the next cycle; `out_row` wraps to 0.
- `WIDTH=20`: beat 2 carries pixels 16..19 in lanes 0..3; lanes 4..7 are 0.
- Reset asserted during beat 1 of row 5 → all outputs at reset values the next cycle. The next accepted row reports `out_row=0`.
- `row_valid` held high during `SEND` with `out_ready` toggling → new row is captured only on the last-beat handshake, and no row is accepted twice.
